// File: rtl/wav_pwm_out.sv
// Output stage of the WAV player: buffers 8-bit PCM samples in a FIFO, releases
// one per DIV clocks and renders it as 8-bit PWM with amplifier enable and underrun report.
module wav_pwm_out #(
    parameter int DIV       = 12500,
    parameter int DEPTH     = 16,
    parameter int PRIME_LVL = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     enable,
    input  logic [7:0]               s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     audio_out,
    output logic                     audio_sd,
    output logic                     underrun,
    output logic [7:0]               underrun_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(DIV);

    localparam logic [1:0]    ST_IDLE   = 2'd0;
    localparam logic [1:0]    ST_PRIME  = 2'd1;
    localparam logic [1:0]    ST_RUN    = 2'd2;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [PW:0]   LVL_FULL  = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   LVL_PRIME = (PW + 1)'(PRIME_LVL);
    localparam logic [7:0]    SILENCE   = 8'h80;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   level_q, level_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    pwm_q, pwm_d;
    logic [7:0]    duty_cur_q, duty_cur_d, duty_next_q, duty_next_d;
    logic [7:0]    ucnt_q, ucnt_d;
    logic          audio_q, audio_d, sd_q, sd_d, underrun_q, underrun_d;
    logic [7:0]    mem_q [DEPTH];

    logic full_s, empty_s, ready_s, push_s, pop_s, tick_s;
    logic enter_s, run_s, stop_s, starve_s;

    assign full_s   = (level_q == LVL_FULL);
    assign empty_s  = (level_q == {(PW + 1){1'b0}});
    assign ready_s  = (state_q != ST_IDLE) && !full_s;
    assign push_s   = s_valid && ready_s;
    assign tick_s   = (tick_q == TICK_LAST);
    assign enter_s  = (state_q == ST_PRIME) && enable && (level_q >= LVL_PRIME);
    assign run_s    = (state_q == ST_RUN) && enable;
    assign stop_s   = (state_q != ST_IDLE) && !enable;
    assign starve_s = run_s && tick_s && empty_s;
    assign pop_s    = enter_s || (run_s && tick_s && !empty_s);

    // Playback state machine: enable starts priming, dropping it returns to idle at once.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_PRIME; else state_d = ST_IDLE;
            ST_PRIME: if (!enable) state_d = ST_IDLE;
                      else if (level_q >= LVL_PRIME) state_d = ST_RUN;
                      else state_d = ST_PRIME;
            ST_RUN:   if (!enable) state_d = ST_IDLE; else state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers and occupancy; a stop flushes everything held.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (stop_s) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            level_d  = {(PW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_d = wr_ptr_q + 1'b1; else wr_ptr_d = wr_ptr_q;
            if (pop_s)  rd_ptr_d = rd_ptr_q + 1'b1; else rd_ptr_d = rd_ptr_q;
            if (push_s && !pop_s)      level_d = level_q + 1'b1;
            else if (!push_s && pop_s) level_d = level_q - 1'b1;
            else                       level_d = level_q;
        end
    end

    // Sample clock, PWM counter and duty pipeline; duty_cur only moves at a PWM wrap.
    always_comb begin
        tick_d      = tick_q;
        pwm_d       = pwm_q;
        duty_cur_d  = duty_cur_q;
        duty_next_d = duty_next_q;
        ucnt_d      = ucnt_q;
        if (enter_s) begin
            tick_d      = {TW{1'b0}};
            pwm_d       = 8'h00;
            duty_cur_d  = SILENCE;
            duty_next_d = mem_q[rd_ptr_q];
            ucnt_d      = 8'h00;
        end else if (run_s) begin
            if (tick_s) tick_d = {TW{1'b0}}; else tick_d = tick_q + 1'b1;
            pwm_d = pwm_q + 1'b1;
            if (pwm_q == 8'hFF) duty_cur_d = duty_next_q; else duty_cur_d = duty_cur_q;
            if (tick_s && empty_s) begin
                duty_next_d = SILENCE;
                if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 1'b1; else ucnt_d = ucnt_q;
            end else if (tick_s) begin
                duty_next_d = mem_q[rd_ptr_q];
            end else begin
                duty_next_d = duty_next_q;
            end
        end else begin
            tick_d = {TW{1'b0}};
            pwm_d  = 8'h00;
        end
    end

    // Registered outputs; quiet on the same edge that leaves RUN.
    always_comb begin
        audio_d    = run_s && (pwm_q < duty_cur_q);
        sd_d       = (state_d == ST_RUN);
        underrun_d = starve_s;
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            level_q     <= {(PW + 1){1'b0}};
            tick_q      <= {TW{1'b0}};
            pwm_q       <= 8'h00;
            duty_cur_q  <= SILENCE;
            duty_next_q <= SILENCE;
            ucnt_q      <= 8'h00;
            audio_q     <= 1'b0;
            sd_q        <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            tick_q      <= tick_d;
            pwm_q       <= pwm_d;
            duty_cur_q  <= duty_cur_d;
            duty_next_q <= duty_next_d;
            ucnt_q      <= ucnt_d;
            audio_q     <= audio_d;
            sd_q        <= sd_d;
            underrun_q  <= underrun_d;
        end
    end

    // Sample storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge CLK) begin
        if (push_s && !RST) mem_q[wr_ptr_q] <= s_data;
    end

    assign s_ready      = ready_s;
    assign audio_out    = audio_q;
    assign audio_sd     = sd_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;
    assign fifo_level   = level_q;
endmodule

// File: tb/tb_wav_pwm_out.sv
// Bench for wav_pwm_out: queue-based model checked every cycle plus
// hand-computed period high counts, backpressure, underrun and stop checks.
module tb_wav_pwm_out;
    localparam int DIV       = 256;
    localparam int DEPTH     = 16;
    localparam int PRIME_LVL = 8;
    localparam int K_LIMIT   = 80000;

    logic       clk = 1'b0;
    logic       rst, enable, s_valid;
    logic [7:0] s_data;
    logic       s_ready, audio_out, audio_sd, underrun;
    logic [7:0] underrun_cnt;
    logic [4:0] fifo_level;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wav_pwm_out #(.DIV(DIV), .DEPTH(DEPTH), .PRIME_LVL(PRIME_LVL)) dut (
        .CLK(clk), .RST(rst), .enable(enable), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .audio_out(audio_out), .audio_sd(audio_sd),
        .underrun(underrun), .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 priming, 2 running; k = cycles spent in RUN.
    int         m_mode = 0;
    logic [7:0] m_q [$];
    int         m_k = 0;
    int         m_dn = 128, m_dc = 128;
    int         e_cnt = 0, e_level = 0;
    logic       e_audio = 1'b0, e_sd = 1'b0, e_ur = 1'b0, e_ready = 1'b0;
    bit         m_live = 1'b0;

    task automatic model_step();
        bit pushed;
        if (rst) begin
            m_mode = 0; m_q.delete(); m_k = 0; m_dn = 128; m_dc = 128;
            e_cnt = 0; e_audio = 1'b0; e_sd = 1'b0; e_ur = 1'b0; e_ready = 1'b0; e_level = 0;
            m_live = 1'b1;
        end else begin
            pushed  = s_valid && e_ready;
            e_ur    = 1'b0;
            e_audio = 1'b0;
            if (m_mode == 0) begin
                if (enable) m_mode = 1;
            end else if (!enable) begin
                m_mode = 0;
                m_q.delete();
            end else if (m_mode == 1) begin
                if (m_q.size() >= PRIME_LVL) begin
                    m_dn = int'(m_q.pop_front()); m_dc = 128; m_k = 0; e_cnt = 0; m_mode = 2;
                end
                if (pushed) m_q.push_back(s_data);
            end else begin
                e_audio = ((m_k % 256) < m_dc);
                if ((m_k % 256) == 255) m_dc = m_dn;
                if ((m_k % DIV) == DIV - 1) begin
                    if (m_q.size() > 0) m_dn = int'(m_q.pop_front());
                    else begin
                        m_dn = 128; e_ur = 1'b1;
                        if (e_cnt < 255) e_cnt++;
                    end
                end
                if (pushed) m_q.push_back(s_data);
                m_k++;
            end
            e_sd    = (m_mode == 2);
            e_level = m_q.size();
            e_ready = (m_mode != 0) && (m_q.size() < DEPTH);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("s_ready", 32'(s_ready), 32'(e_ready));
            chk("audio_out", 32'(audio_out), 32'(e_audio));
            chk("audio_sd", 32'(audio_sd), 32'(e_sd));
            chk("underrun", 32'(underrun), 32'(e_ur));
            chk("underrun_cnt", 32'(underrun_cnt), e_cnt);
            chk("fifo_level", 32'(fifo_level), e_level);
        end
    end

    task automatic wait_k(input int target);
        int n = 0;
        while (m_k != target && n < K_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (m_k != target) begin
            checks++;
            failures++;
            $display("FAIL wait_k actual=%0d required=%0d", m_k, target);
        end
    endtask

    // Counts high and underrun cycles over the output window of PWM period p.
    task automatic measure(input int p, output int hi, output int ur);
        hi = 0;
        ur = 0;
        wait_k(256 * p + 1);
        for (int i = 0; i < 256; i++) begin
            hi += int'(audio_out);
            ur += int'(underrun);
            @(negedge clk);
        end
    endtask

    initial begin
        int hi, ur, acc;
        rst = 1'b1; enable = 1'b1; s_valid = 1'b1; s_data = 8'h40;
        repeat (3) begin
            @(negedge clk);
            chk("rst_audio", 32'(audio_out), 32'd0);
            chk("rst_sd", 32'(audio_sd), 32'd0);
            chk("rst_level", 32'(fifo_level), 32'd0);
        end
        rst = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("prime_ready", 32'(s_ready), 32'd1);

        s_valid = 1'b1; s_data = 8'h40;
        repeat (8) @(negedge clk);
        s_valid = 1'b0;
        chk("prime_level8", 32'(fifo_level), 32'd8);
        chk("prime_sd", 32'(audio_sd), 32'd0);
        @(negedge clk);
        chk("run_sd", 32'(audio_sd), 32'd1);
        chk("run_level", 32'(fifo_level), 32'd7);

        s_valid = 1'b1; s_data = 8'h00;
        @(negedge clk);
        s_data = 8'hFF;
        @(negedge clk);
        s_valid = 1'b0;

        measure(1, hi, ur);  chk("tone_p1_high", hi, 32'd64);
        measure(2, hi, ur);  chk("tone_p2_high", hi, 32'd64);
        measure(9, hi, ur);  chk("duty00_high", hi, 32'd0);
        chk("first_underrun_pulses", ur, 32'd1);
        chk("first_underrun_cnt", 32'(underrun_cnt), 32'd1);
        measure(10, hi, ur); chk("dutyFF_high", hi, 32'd255);
        measure(11, hi, ur); chk("silence_high", hi, 32'd128);
        chk("underrun_cnt3", 32'(underrun_cnt), 32'd3);

        wait_k(256 * 266 + 2);
        chk("underrun_sat", 32'(underrun_cnt), 32'd255);

        s_valid = 1'b1; s_data = 8'h33; acc = 0;
        for (int i = 0; i < 20; i++) begin
            acc += int'(s_ready);
            @(negedge clk);
        end
        chk("bp_accepts", acc, 32'd16);
        chk("bp_level", 32'(fifo_level), 32'd16);
        chk("bp_ready", 32'(s_ready), 32'd0);
        wait_k(256 * 267);
        chk("bp_tick_level", 32'(fifo_level), 32'd15);
        @(negedge clk);
        chk("bp_refill_level", 32'(fifo_level), 32'd16);

        s_valid = 1'b0;
        wait_k(256 * 278 + 10);
        chk("stop_pre_level", 32'(fifo_level), 32'd5);
        chk("stop_pre_audio", 32'(audio_out), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("stop_level", 32'(fifo_level), 32'd0);
        chk("stop_audio", 32'(audio_out), 32'd0);
        chk("stop_sd", 32'(audio_sd), 32'd0);
        chk("stop_ready", 32'(s_ready), 32'd0);
        chk("stop_cnt_hold", 32'(underrun_cnt), 32'd255);

        enable = 1'b1;
        @(negedge clk);
        s_valid = 1'b1; s_data = 8'hC0;
        repeat (8) @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        chk("rerun_sd", 32'(audio_sd), 32'd1);
        chk("rerun_cnt_clear", 32'(underrun_cnt), 32'd0);
        measure(1, hi, ur);
        chk("rerun_p1_high", hi, 32'd192);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
